// File: rtl/clint.sv
// CLINT: msip, mtimecmp and mtime registers behind a single-beat valid/ready bus.
// Define CLINT_PRESCALER_EN to advance mtime once every CLK_DIV clocks instead of every clock.
module clint #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic [15:0] ADDR_MSIP      = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP0 = 16'h4000;
    localparam logic [15:0] ADDR_MTIMECMP1 = 16'h4004;
    localparam logic [15:0] ADDR_MTIME0    = 16'hBFF8;
    localparam logic [15:0] ADDR_MTIME1    = 16'hBFFC;

    logic [0:0]  state;
    logic        msip_q;
    logic        mtip_q;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        wr_en;
    logic [15:0] offs;
    logic [15:0] addr_hi_unused;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic [31:0] rd_val;
    logic        tick;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign offs           = clint_addr[15:0];
    assign addr_hi_unused = clint_addr[31:16];

    assign accept = (state == IDLE) && clint_valid;
    assign wr_en  = accept && (clint_wstrb != 4'b0000);

    always_comb begin
        sel_msip    = 1'b0;
        sel_cmp_lo  = 1'b0;
        sel_cmp_hi  = 1'b0;
        sel_time_lo = 1'b0;
        sel_time_hi = 1'b0;
        case (offs)
            ADDR_MSIP:      sel_msip    = 1'b1;
            ADDR_MTIMECMP0: sel_cmp_lo  = 1'b1;
            ADDR_MTIMECMP1: sel_cmp_hi  = 1'b1;
            ADDR_MTIME0:    sel_time_lo = 1'b1;
            ADDR_MTIME1:    sel_time_hi = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (sel_msip)    rd_val = {31'd0, msip_q};
        if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
        if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
        if (sel_time_lo) rd_val = mtime_q[31:0];
        if (sel_time_hi) rd_val = mtime_q[63:32];
    end

`ifdef CLINT_PRESCALER_EN
    logic [15:0] presc_cnt;

    assign tick = (presc_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end
`else
    logic [15:0] clk_div_unused;

    assign clk_div_unused = 16'(CLK_DIV);
    assign tick           = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (accept) begin
            state <= RESP;
        end else begin
            state <= IDLE;
        end
    end

    // Read data is latched on the accepting edge and cleared on every other
    // edge, so it is non-zero only during the single RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= rd_val;
        end else begin
            rdata_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            msip_q <= 1'b0;
        end else if (wr_en && sel_msip && clint_wstrb[0]) begin
            msip_q <= clint_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtimecmp_q <= '1;
        end else if (wr_en && sel_cmp_lo) begin
            mtimecmp_q[31:0] <= byte_merge(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
        end else if (wr_en && sel_cmp_hi) begin
            mtimecmp_q[63:32] <= byte_merge(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
        end
    end

    // A bus write to either mtime half suppresses the tick for the whole
    // 64-bit counter on that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q <= '0;
        end else if (wr_en && sel_time_lo) begin
            mtime_q <= {mtime_q[63:32], byte_merge(mtime_q[31:0], clint_wdata, clint_wstrb)};
        end else if (wr_en && sel_time_hi) begin
            mtime_q <= {byte_merge(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtip_q <= 1'b0;
        end else begin
            mtip_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign clint_ready = (state == RESP);
    assign clint_rdata = rdata_q;
    assign msip        = msip_q;
    assign mtip        = mtip_q;
    assign mtime       = mtime_q;

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter: CLK_DIV, default 100, clk cycles per mtime tick when prescaler compiled in; legal range 2..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 clint_valid  input  1  request strobe; held high by initiator until clint_ready.
REQ-005 clint_addr  input  32  byte address; only bits [15:0] decoded.
REQ-006 clint_wdata  input  32  write data.
REQ-007 clint_wstrb  input  4  byte write enables; 0 means read.
REQ-008 clint_rdata  output  32  read data, valid while clint_ready high.
REQ-009 clint_ready  output  1  one-cycle completion pulse.
REQ-010 msip  output  1  machine software interrupt pending, to core csr.
REQ-011 mtip  output  1  machine timer interrupt pending, to core csr.
REQ-012 mtime  output  64  current timer value, to core csr.

Function
REQ-013 Register map (addr[15:0]): 0x0000 msip (bit 0 only, others read 0), 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-014 Handshake FSM states IDLE, RESP: IDLE + clint_valid -> RESP (access performed on this edge); RESP -> IDLE unconditionally.
REQ-015 clint_ready high exactly in RESP, one cycle; latency one cycle from accepted clint_valid.
REQ-016 In RESP clint_valid is ignored; a still-high clint_valid in the following IDLE cycle starts a new access.
REQ-017 Writes apply per byte lane of clint_wstrb; read when clint_wstrb = 0.
REQ-018 Unmapped addresses: read returns 0, write ignored, clint_ready still pulsed.
REQ-019 clint_rdata = 0 outside RESP.
REQ-020 mtime increments by 1 per tick, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-021 Bus write to mtime half on same edge as tick: written bytes take write data, unwritten bytes of that half keep old value, other half not incremented that edge.
REQ-022 Reads of mtime halves are independent; no hi/lo snapshot.
REQ-023 mtip registered: mtip = (mtime >= mtimecmp) evaluated on register values each edge, unsigned 64-bit compare; one-cycle lag after any mtime/mtimecmp change.
REQ-024 msip output equals msip register bit 0 directly.
REQ-025 mtime output equals mtime register directly.

Reset
REQ-026 On rst = 0 at a clk edge: FSM IDLE, clint_ready 0, clint_rdata 0, msip 0, mtime 0, mtimecmp 0xFFFF_FFFF_FFFF_FFFF, mtip 0, prescaler counter 0.
REQ-027 Reset asserted while in RESP aborts the response; no ready pulse after reset deasserts for that request.

Configuration
REQ-028 Macro CLINT_PRESCALER_EN defined: counter counts 0..CLK_DIV-1, tick when counter = CLK_DIV-1, counter then returns to 0; bus writes do not affect the counter.
REQ-029 CLINT_PRESCALER_EN undefined: no counter, tick every clk cycle, CLK_DIV unused.

Verification
REQ-030 Reset release, idle 10 cycles (prescaler off) -> mtime = 10, mtip = 0, msip = 0, clint_ready never high.
REQ-031 Write 0x0000 wdata 0x1 wstrb 0xF -> clint_ready next cycle, msip = 1; read 0x0000 -> rdata 0x1; write 0x0 -> msip = 0.
REQ-032 Write mtimecmp = 0x0000_0000_0000_0020 (prescaler off) -> mtip rises the cycle after mtime reaches 0x20; write mtimecmp hi 0xFFFF_FFFF -> mtip falls within 2 cycles.
REQ-033 Write mtime lo 0xFFFF_FFFF and hi 0xFFFF_FFFF -> mtime wraps to 0 on next tick; write mtime lo wstrb 0x1 wdata 0xAB on tick edge -> byte 0 = 0xAB, bytes 1..3 unchanged, no increment.
REQ-034 Read 0x1234 -> rdata 0, ready pulsed; write 0x1234 -> no register changed.
REQ-035 CLINT_PRESCALER_EN, CLK_DIV = 4: 40 cycles after reset -> mtime = 10; assert rst mid-RESP -> ready 0, all registers at reset values.
